// File: rtl/reg16_pkg.sv
// Shared encodings for the 16-bit storage register access master.
// Holds the host op codes, the FSM states and the default data width.
package reg16_pkg;

    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_WVERIFY = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/reg16_access_master_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// It sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/reg16_access_master.sv
// Host-command initiator for one single-register storage element (in / read_write / out).
// It sequences writes and reads, captures readback data and returns data and status.
module reg16_access_master
    import reg16_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned ERR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [DATA_W-1:0] reg_in,
    output logic              reg_rw,
    input  logic [DATA_W-1:0] reg_out
);

    localparam int unsigned CNT_W = $clog2(READ_LAT + 1);

    state_e            state, state_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] resp_data_d;
    logic              resp_err_d;
    logic              err_inc;
    logic              accept;

    assign cmd_ready  = (state == ST_IDLE) && !reset;
    assign accept     = cmd_valid && cmd_ready;
    assign resp_valid = (state == ST_RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        op_d        = op_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data;
        resp_err_d  = resp_err;
        err_inc     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = op_e'(cmd_op);
                    wdata_d = cmd_wdata;
                    case (op_e'(cmd_op))
                        OP_READ:              state_d = ST_RD_ISSUE;
                        OP_WRITE, OP_WVERIFY: state_d = ST_WR;
                        default: begin
                            state_d     = ST_RESP;
                            resp_data_d = '0;
                            resp_err_d  = 1'b1;
                        end
                    endcase
                end
            end
            ST_WR: begin
                if (op_q == OP_WRITE) begin
                    state_d     = ST_RESP;
                    resp_data_d = wdata_q;
                    resp_err_d  = 1'b0;
                end else begin
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
                cnt_d   = CNT_W'(READ_LAT);
            end
            ST_RD_WAIT: begin
                // reg_out is valid on the last wait cycle; capture at its closing edge
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_RESP;
                    resp_data_d = reg_out;
                    if (op_q == OP_WVERIFY) begin
                        resp_err_d = (reg_out != wdata_q);
                        err_inc    = (reg_out != wdata_q);
                    end else begin
                        resp_err_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Storage strobes are registered from the next state so reg_rw is high exactly during WR
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= OP_READ;
            wdata_q   <= '0;
            cnt_q     <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            reg_rw    <= 1'b0;
            reg_in    <= '0;
        end else begin
            op_q      <= op_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            resp_data <= resp_data_d;
            resp_err  <= resp_err_d;
            reg_rw    <= (state_d == ST_WR);
            if (state_d == ST_WR) begin
                reg_in <= wdata_d;
            end
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (err_inc),
        .count(err_cnt)
    );

endmodule

// File: tb/tb_reg16_access_master.sv
// Directed bench for reg16_access_master with a behavioural storage register as responder.
// Expected responses are queued at command issue and compared when the response appears.
module tb_reg16_access_master;
    import reg16_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [15:0] resp_data;
    logic        resp_err;
    logic [7:0]  err_cnt;
    logic [15:0] reg_in;
    logic        reg_rw;
    logic [15:0] reg_out;

    logic [15:0] stor_mem = '0;
    logic [15:0] stor_out = '0;
    logic        force_zero = 1'b0;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          lat;
        int          rw;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  exp_err_cnt = '0;
    logic [15:0] last_wr = '0;

    always #5 clk = ~clk;

    // Storage register: writes on read_write=1, otherwise refreshes out
    always @(posedge clk) begin
        if (reg_rw) stor_mem <= reg_in;
        else        stor_out <= stor_mem;
    end
    assign reg_out = force_zero ? 16'h0000 : stor_out;

    reg16_access_master #(
        .DATA_W  (16),
        .READ_LAT(1),
        .ERR_W   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_wdata (cmd_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .err_cnt   (err_cnt),
        .reg_in    (reg_in),
        .reg_rw    (reg_rw),
        .reg_out   (reg_out)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [15:0] wdata,
                          input logic [15:0] exp_data, input logic exp_err,
                          input int lat, input int rw_exp, input int stall);
        exp_t e;
        exp_t got;
        int   cyc;
        int   rw_cnt;
        e.data = exp_data; e.err = exp_err; e.lat = lat; e.rw = rw_exp;
        sb.push_back(e);
        if (op == OP_WVERIFY && exp_err && exp_err_cnt != 8'hFF) exp_err_cnt++;
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        resp_ready = (stall == 0);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_wdata  = wdata;
        tick();
        cmd_valid = 1'b0;
        cyc = 1;
        rw_cnt = 0;
        while (1) begin
            if (reg_rw) begin
                rw_cnt++;
                check("reg_in", {16'd0, reg_in}, {16'd0, wdata});
            end
            if (resp_valid || cyc >= 64) break;
            tick();
            cyc++;
        end
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check("latency", cyc, got.lat);
            check("resp_data", {16'd0, resp_data}, {16'd0, got.data});
            check("resp_err", {31'd0, resp_err}, {31'd0, got.err});
            check("rw_pulses", rw_cnt, got.rw);
            check("err_cnt", {24'd0, err_cnt}, {24'd0, exp_err_cnt});
        end
        for (int s = 0; s < stall; s++) begin
            cmd_valid = s[0];
            cmd_op    = OP_WRITE;
            cmd_wdata = 16'hDEAD;
            tick();
            check("stall_valid", {31'd0, resp_valid}, 32'd1);
            check("stall_data", {16'd0, resp_data}, {16'd0, exp_data});
            check("stall_ready", {31'd0, cmd_ready}, 32'd0);
            check("stall_rw", {31'd0, reg_rw}, 32'd0);
        end
        cmd_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        check("resp_cleared", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        // Reset values
        tick();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_data", {16'd0, resp_data}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_reg_rw", {31'd0, reg_rw}, 32'd0);
        check("rst_reg_in", {16'd0, reg_in}, 32'd0);

        // 1: WRITE
        last_wr = 16'hA5A5;
        do_cmd(OP_WRITE, 16'hA5A5, 16'hA5A5, 1'b0, 2, 1, 0);

        // 2: WRITE then READ
        last_wr = 16'h1234;
        do_cmd(OP_WRITE, 16'h1234, 16'h1234, 1'b0, 2, 1, 0);
        do_cmd(OP_READ, 16'h0000, last_wr, 1'b0, 3, 0, 0);

        // 3: WRITE_VERIFY clean, then with forced readback
        last_wr = 16'hBEEF;
        do_cmd(OP_WVERIFY, 16'hBEEF, 16'hBEEF, 1'b0, 4, 1, 0);
        force_zero = 1'b1;
        last_wr = 16'h5A5A;
        do_cmd(OP_WVERIFY, 16'h5A5A, 16'h0000, 1'b1, 4, 1, 0);
        force_zero = 1'b0;

        // 4: stalled READ response; ignored command pulses must not reach storage
        do_cmd(OP_READ, 16'h0000, last_wr, 1'b0, 3, 0, 10);
        do_cmd(OP_READ, 16'h0000, last_wr, 1'b0, 3, 0, 0);

        // 5: illegal op, then saturate the mismatch counter
        do_cmd(OP_ILLEGAL, 16'hFFFF, 16'h0000, 1'b1, 1, 0, 0);
        force_zero = 1'b1;
        for (int i = 0; i < 256; i++) begin
            last_wr = 16'h8000 | 16'(i);
            do_cmd(OP_WVERIFY, last_wr, 16'h0000, 1'b1, 4, 1, 0);
        end
        force_zero = 1'b0;
        check("err_cnt_sat", {24'd0, err_cnt}, 32'h000000FF);

        // 6: reset during RD_WAIT
        cmd_valid = 1'b1;
        cmd_op    = OP_READ;
        tick();
        cmd_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("abort_reg_rw", {31'd0, reg_rw}, 32'd0);
        check("abort_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        exp_err_cnt = '0;
        reset = 1'b0;
        #1;
        check("post_reset_ready", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_aborted_resp", {31'd0, resp_valid}, 32'd0);
        end
        do_cmd(OP_READ, 16'h0000, last_wr, 1'b0, 3, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
